// File: rtl/universal_shift_reg.sv
// universal_shift_reg: parametrised staging register with load, clear, logical and
// arithmetic shifts, and rotates.
// Multi-bit shifts and rotates step one bit per cycle behind a start/busy/done handshake.
// Optional macro UNIVERSAL_SHIFT_PARITY_EN adds a registered parity_out output.

module universal_shift_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] shamt,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             serial_in_left,
    input  logic             serial_in_right,
    output logic [WIDTH-1:0] parallel_out,
    output logic             serial_out_left,
    output logic             serial_out_right,
    output logic             busy,
    output logic             done
`ifdef UNIVERSAL_SHIFT_PARITY_EN
    ,
    output logic             parity_out
`endif
);

    localparam logic [2:0] ModeHold = 3'b000;
    localparam logic [2:0] ModeLoad = 3'b001;
    localparam logic [2:0] ModeShl  = 3'b010;
    localparam logic [2:0] ModeShr  = 3'b011;
    localparam logic [2:0] ModeRol  = 3'b100;
    localparam logic [2:0] ModeRor  = 3'b101;
    localparam logic [2:0] ModeAsr  = 3'b110;
    localparam logic [2:0] ModeClr  = 3'b111;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Single 1-bit step of a shift/rotate mode; non-stepping modes pass the value through.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] q,
        input logic             fill_l,
        input logic             fill_r
    );
        logic [WIDTH-1:0] r;
        r = q;
        case (op)
            ModeShl: r = {q[WIDTH-2:0], fill_r};
            ModeShr: r = {fill_l, q[WIDTH-1:1]};
            ModeRol: r = {q[WIDTH-2:0], q[WIDTH-1]};
            ModeRor: r = {q[0], q[WIDTH-1:1]};
            ModeAsr: r = {q[WIDTH-1], q[WIDTH-1:1]};
            default: r = q;
        endcase
        return r;
    endfunction

    function automatic logic is_step_mode(input logic [2:0] op);
        return (op != ModeHold) && (op != ModeLoad) && (op != ModeClr);
    endfunction

    // Next-state logic: command capture in idle, one step per cycle while shifting.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (is_step_mode(mode)) begin
                        // The capture edge performs the first step, so only shamt-1 remain.
                        if (shamt != '0) begin
                            data_d = shift_step(mode, data_q, serial_in_left, serial_in_right);
                        end
                        if (shamt > CntOne) begin
                            state_d = StShift;
                            op_d    = mode;
                            cnt_d   = shamt - CntOne;
                            busy_d  = 1'b1;
                        end else begin
                            done_d = 1'b1;
                        end
                    end else begin
                        case (mode)
                            ModeLoad: data_d = parallel_in;
                            ModeClr:  data_d = '0;
                            default:  data_d = data_q;
                        endcase
                        done_d = 1'b1;
                    end
                end
            end
            StShift: begin
                data_d = shift_step(op_q, data_q, serial_in_left, serial_in_right);
                cnt_d  = cnt_q - CntOne;
                if (cnt_q == CntOne) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, data and handshake registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            data_q  <= '0;
            cnt_q   <= '0;
            op_q    <= ModeHold;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef UNIVERSAL_SHIFT_PARITY_EN
    logic parity_q;

    // Parity tracks the register by computing it from the next value on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^data_d;
        end
    end

    assign parity_out = parity_q;
`endif

    assign parallel_out     = data_q;
    assign serial_out_left  = data_q[WIDTH-1];
    assign serial_out_right = data_q[0];
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg (WIDTH=8): a scoreboard queue is filled when
// each command is issued and drained whenever done pulses.

module tb_universal_shift_reg;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk;
    logic          rst;
    logic          start;
    logic [2:0]    mode;
    logic [CW-1:0] shamt;
    logic [W-1:0]  pin;
    logic          sil;
    logic          sir;
    logic [W-1:0]  pout;
    logic          sol;
    logic          sor;
    logic          busy;
    logic          done;
`ifdef UNIVERSAL_SHIFT_PARITY_EN
    logic          parity;
`endif

    int n_checks   = 0;
    int n_fail     = 0;
    int done_count = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] shadow;

    universal_shift_reg #(
        .WIDTH(W),
        .CNT_W(CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .mode            (mode),
        .shamt           (shamt),
        .parallel_in     (pin),
        .serial_in_left  (sil),
        .serial_in_right (sir),
        .parallel_out    (pout),
        .serial_out_left (sol),
        .serial_out_right(sor),
        .busy            (busy),
        .done            (done)
`ifdef UNIVERSAL_SHIFT_PARITY_EN
        ,
        .parity_out      (parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference behaviour of a whole command with constant fill bits.
    function automatic logic [W-1:0] model_cmd(input logic [W-1:0] v0, input logic [2:0] m,
                                               input int n, input logic [W-1:0] ld,
                                               input logic fl, input logic fr);
        logic [W-1:0] v;
        v = v0;
        case (m)
            3'd0: v = v0;
            3'd1: v = ld;
            3'd7: v = '0;
            default: begin
                for (int i = 0; i < n; i++) begin
                    case (m)
                        3'd2: v = (v << 1) | W'(fr);
                        3'd3: v = (v >> 1) | (W'(fl) << (W - 1));
                        3'd4: v = (v << 1) | (v >> (W - 1));
                        3'd5: v = (v >> 1) | (v << (W - 1));
                        default: v = W'($signed(v) >>> 1);
                    endcase
                end
            end
        endcase
        return v;
    endfunction

    // Scoreboard drain: every done pulse must match the oldest outstanding command.
    always @(negedge clk) begin
        if (!rst && done) begin
            logic [W-1:0] e;
            done_count++;
            check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("sb_data", 32'(pout), 32'(e));
                check_eq("sb_sol", 32'(sol), 32'(e[W-1]));
                check_eq("sb_sor", 32'(sor), 32'(e[0]));
                check_eq("sb_busy_low", 32'(busy), 32'd0);
`ifdef UNIVERSAL_SHIFT_PARITY_EN
                check_eq("sb_parity", 32'(parity), 32'(^e));
`endif
            end
        end
    end

    task automatic wait_done(input string tag, output int busy_cycles);
        int cyc;
        cyc = 0;
        busy_cycles = 0;
        while (!done && cyc < 200) begin
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq({tag, "_timeout"}, 32'(cyc < 200), 32'd1);
    endtask

    task automatic issue(input logic [2:0] m, input int sa, input logic [W-1:0] ld,
                         input logic fl, input logic fr);
        logic [W-1:0] e;
        e = model_cmd(shadow, m, sa, ld, fl, fr);
        shadow = e;
        exp_q.push_back(e);
        start = 1'b1;
        mode  = m;
        shamt = CW'(sa);
        pin   = ld;
        sil   = fl;
        sir   = fr;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_cmd(input string tag, input logic [2:0] m, input int sa,
                           input logic [W-1:0] ld, input logic fl, input logic fr);
        int bc;
        int exp_bc;
        exp_bc = (m >= 3'd2 && m <= 3'd6 && sa >= 2) ? sa - 1 : 0;
        issue(m, sa, ld, fl, fr);
        wait_done(tag, bc);
        check_eq({tag, "_busy_cycles"}, 32'(bc), 32'(exp_bc));
        @(posedge clk);
        #1;
        check_eq({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        int bc;
        int snap;
        rst    = 1'b0;
        start  = 1'b0;
        mode   = 3'd0;
        shamt  = '0;
        pin    = '0;
        sil    = 1'b0;
        sir    = 1'b0;
        shadow = '0;
        #2 rst = 1'b1;
        #2;
        check_eq("reset_data", 32'(pout), 32'h0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Load, then the directed shift/rotate cases.
        run_cmd("load_a5", 3'd1, 0, 8'hA5, 1'b0, 1'b0);
        check_eq("load_a5_val", 32'(pout), 32'hA5);
        run_cmd("load_81", 3'd1, 0, 8'h81, 1'b0, 1'b0);
        run_cmd("shl3_fill", 3'd2, 3, 8'h00, 1'b0, 1'b1);
        check_eq("shl3_fill_val", 32'(pout), 32'h0F);
        run_cmd("load_01", 3'd1, 0, 8'h01, 1'b0, 1'b0);
        run_cmd("ror8", 3'd5, 8, 8'h00, 1'b0, 1'b0);
        check_eq("ror8_val", 32'(pout), 32'h01);
        run_cmd("load_80a", 3'd1, 0, 8'h80, 1'b0, 1'b0);
        run_cmd("asr3", 3'd6, 3, 8'h00, 1'b0, 1'b0);
        check_eq("asr3_val", 32'(pout), 32'hF0);
        run_cmd("load_80b", 3'd1, 0, 8'h80, 1'b0, 1'b0);
        run_cmd("rol1", 3'd4, 1, 8'h00, 1'b0, 1'b0);
        check_eq("rol1_val", 32'(pout), 32'h01);
        run_cmd("load_c3", 3'd1, 0, 8'hC3, 1'b0, 1'b0);
        run_cmd("rol8", 3'd4, 8, 8'h00, 1'b0, 1'b0);
        check_eq("rol8_val", 32'(pout), 32'hC3);
        run_cmd("shl0", 3'd2, 0, 8'h00, 1'b0, 1'b1);
        check_eq("shl0_val", 32'(pout), 32'hC3);
        run_cmd("shl10_fill1", 3'd2, 10, 8'h00, 1'b0, 1'b1);
        check_eq("shl10_val", 32'(pout), 32'hFF);
        run_cmd("hold", 3'd0, 0, 8'h12, 1'b0, 1'b0);
        check_eq("hold_val", 32'(pout), 32'hFF);
        run_cmd("clr", 3'd7, 0, 8'h12, 1'b0, 1'b0);
        check_eq("clr_val", 32'(pout), 32'h00);

        // A clear strobed mid-shift must be ignored.
        run_cmd("load_b6", 3'd1, 0, 8'hB6, 1'b0, 1'b0);
        snap = done_count;
        issue(3'd3, 5, 8'h00, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b1;
        mode  = 3'd7;
        shamt = '0;
        pin   = 8'hFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("shr5_ignore", bc);
        check_eq("shr5_val", 32'(pout), 32'hFD);
        repeat (3) @(posedge clk);
        #1;
        check_eq("shr5_done_once", 32'(done_count - snap), 32'd1);
        check_eq("shr5_idle", 32'(busy), 32'd0);

        // Back-to-back: new command issued in the cycle done is high.
        issue(3'd1, 0, 8'h3C, 1'b0, 1'b0);
        check_eq("b2b_done_high", 32'(done), 32'd1);
        issue(3'd2, 2, 8'h00, 1'b0, 1'b0);
        wait_done("b2b_shl2", bc);
        check_eq("b2b_val", 32'(pout), 32'hF0);
        @(posedge clk);
        #1;

`ifdef UNIVERSAL_SHIFT_PARITY_EN
        run_cmd("load_07", 3'd1, 0, 8'h07, 1'b0, 1'b0);
        check_eq("parity_07", 32'(parity), 32'd1);
        run_cmd("load_03", 3'd1, 0, 8'h03, 1'b0, 1'b0);
        check_eq("parity_03", 32'(parity), 32'd0);
`endif

        // Randomised commands against the model.
        for (int i = 0; i < 24; i++) begin
            run_cmd("rand", 3'($urandom_range(0, 7)), int'($urandom_range(0, 10)),
                    W'($urandom), 1'($urandom), 1'($urandom));
        end

        // Asynchronous reset in the middle of a rotate.
        run_cmd("load_5a", 3'd1, 0, 8'h5A, 1'b0, 1'b0);
        start = 1'b1;
        mode  = 3'd4;
        shamt = CW'(7);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_mid_busy_before", 32'(busy), 32'd1);
        snap = done_count;
        #2 rst = 1'b1;
        #1;
        check_eq("rst_mid_data", 32'(pout), 32'h00);
        check_eq("rst_mid_busy", 32'(busy), 32'd0);
        check_eq("rst_mid_done", 32'(done), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        shadow = '0;
        repeat (10) @(posedge clk);
        #1;
        check_eq("rst_mid_no_done", 32'(done_count - snap), 32'd0);
        check_eq("rst_mid_stays", 32'(pout), 32'h00);
        run_cmd("post_rst_load", 3'd1, 0, 8'h69, 1'b0, 1'b0);
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
